// File: rtl/sw_pkg.sv
// Shared constants and helpers for the slide-switch conditioning block.
// Imported by the per-channel debouncer and the top.
package sw_pkg;

    localparam int SW_WIDTH            = 12;
    localparam int SW_DEBOUNCE_DEFAULT = 50000;
    localparam int SW_CNT_W            = 16;

    // True when a w-bit counter can hold cycles-1 and cycles is legal.
    function automatic bit sw_cnt_w_ok(input int cycles, input int w);
        longint lim;
        lim = longint'(1) << w;
        return (cycles >= 2) && (longint'(cycles) < lim);
    endfunction

endpackage

// File: rtl/debounce_ch.sv
// One switch channel: two-flop synchroniser plus stability counter.
// A new level is accepted only after it has been stable long enough.
module debounce_ch
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = SW_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic chg
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous switch level into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
        end
    end

    // Count consecutive mismatching cycles; accept at the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            dout <= 1'b0;
            chg  <= 1'b0;
        end else begin
            chg <= 1'b0;
            if (s2 == dout) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                dout <= s2;
                chg  <= 1'b1;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounced board slide switches with change pulses and a
// post-reset settled flag.
module sw_debounce
    import sw_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_DEFAULT,
    parameter int CNT_W           = SW_CNT_W
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [WIDTH-1:0] SW_IN,
    output logic [WIDTH-1:0] SW_OUT,
    output logic [WIDTH-1:0] SW_CHG,
    output logic             SW_VALID
);

    if (!sw_cnt_w_ok(DEBOUNCE_CYCLES, CNT_W)) begin : g_bad_cnt_w
        $error("sw_debounce: CNT_W too small or DEBOUNCE_CYCLES < 2");
    end

    localparam logic [CNT_W:0] ACQ_END = (CNT_W + 1)'(DEBOUNCE_CYCLES + 2);

    logic [CNT_W:0] acq;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk  (CLK),
            .rst_n(RST_N),
            .din  (SW_IN[i]),
            .dout (SW_OUT[i]),
            .chg  (SW_CHG[i])
        );
    end

    // Acquisition window: one sync delay plus a full debounce period.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            acq      <= '0;
            SW_VALID <= 1'b0;
        end else begin
            if (acq != ACQ_END) begin
                acq <= acq + 1'b1;
            end
            if (acq == ACQ_END) begin
                SW_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce with a short debounce period.
// A sliding-window reference model predicts every output cycle.
module tb_sw_debounce;

    localparam int W = 12;
    localparam int D = 4;

    logic         CLK;
    logic         RST_N;
    logic [W-1:0] SW_IN;
    logic [W-1:0] SW_OUT;
    logic [W-1:0] SW_CHG;
    logic         SW_VALID;

    int n_cmp;
    int n_err;

    // Model: input samples of past edges, newest first.
    logic [W-1:0] hist [0:D];
    logic [W-1:0] m_out;
    logic [W-1:0] m_chg;
    logic         m_valid;
    int           n_edge;
    string        tname;

    sw_debounce #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (16)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SW_IN   (SW_IN),
        .SW_OUT  (SW_OUT),
        .SW_CHG  (SW_CHG),
        .SW_VALID(SW_VALID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic model_clear();
        for (int j = 0; j <= D; j++) hist[j] = '0;
        m_out   = '0;
        m_chg   = '0;
        m_valid = 1'b0;
        n_edge  = 0;
    endtask

    // A level is accepted once the synchronised input has differed
    // from the output for D consecutive edges.
    task automatic tick();
        logic [W-1:0] diff;
        @(posedge CLK);
        if (RST_N) begin
            diff = '1;
            for (int j = 1; j <= D; j++) diff &= hist[j] ^ m_out;
            m_out = m_out ^ diff;
            m_chg = diff;
            for (int j = D; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = SW_IN;
            if (n_edge < 1000) n_edge++;
            m_valid = (n_edge >= D + 3);
        end
        #1;
        n_cmp++;
        if (SW_OUT !== m_out) begin
            n_err++;
            $display("FAIL %s sw_out got %h want %h", tname, SW_OUT, m_out);
        end
        n_cmp++;
        if (SW_CHG !== m_chg) begin
            n_err++;
            $display("FAIL %s sw_chg got %h want %h", tname, SW_CHG, m_chg);
        end
        n_cmp++;
        if (SW_VALID !== m_valid) begin
            n_err++;
            $display("FAIL %s sw_valid got %b want %b", tname, SW_VALID, m_valid);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        model_clear();
        #1;
        n_cmp++;
        if ({SW_OUT, SW_CHG, SW_VALID} !== '0) begin
            n_err++;
            $display("FAIL %s reset_zero got %h/%h/%b want 0/0/0",
                     tname, SW_OUT, SW_CHG, SW_VALID);
        end
        repeat (3) tick();
        #2;
        RST_N = 1'b1;
    endtask

    // Explicit acceptance checks for a step applied after reset release.
    task automatic check_acq(input logic [W-1:0] val);
        for (int n = 1; n <= 9; n++) begin
            tick();
            n_cmp++;
            if (SW_OUT !== ((n >= 6) ? val : 12'h000)) begin
                n_err++;
                $display("FAIL %s acq_out edge %0d got %h", tname, n, SW_OUT);
            end
            n_cmp++;
            if (SW_CHG !== ((n == 6) ? val : 12'h000)) begin
                n_err++;
                $display("FAIL %s acq_chg edge %0d got %h", tname, n, SW_CHG);
            end
            n_cmp++;
            if (SW_VALID !== (n >= 7)) begin
                n_err++;
                $display("FAIL %s acq_valid edge %0d got %b", tname, n, SW_VALID);
            end
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        SW_IN = 12'hFFF;
        do_reset();
        check_acq(12'hFFF);
    endtask

    task automatic test_clean_step();
        tname = "clean_step";
        SW_IN = 12'h000;
        repeat (20) tick();
        SW_IN = 12'h001;
        for (int t = 1; t <= 10; t++) begin
            tick();
            n_cmp++;
            if (SW_OUT !== ((t >= 6) ? 12'h001 : 12'h000)) begin
                n_err++;
                $display("FAIL clean_step out t%0d got %h", t, SW_OUT);
            end
            n_cmp++;
            if (SW_CHG !== ((t == 6) ? 12'h001 : 12'h000)) begin
                n_err++;
                $display("FAIL clean_step chg t%0d got %h", t, SW_CHG);
            end
        end
    endtask

    task automatic test_bounce();
        tname = "bounce";
        SW_IN = 12'h000;
        repeat (20) tick();
        for (int i = 0; i < 20; i++) begin
            SW_IN[5] = ((i % 4) < 3);
            tick();
            n_cmp++;
            if (SW_OUT[5] !== 1'b0) begin
                n_err++;
                $display("FAIL bounce held cycle %0d got %b want 0", i, SW_OUT[5]);
            end
        end
        SW_IN[5] = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            tick();
            n_cmp++;
            if (SW_OUT[5] !== (t >= 6)) begin
                n_err++;
                $display("FAIL bounce settle t%0d got %b", t, SW_OUT[5]);
            end
        end
    endtask

    task automatic test_nibbles();
        logic [3:0]   x;
        logic [W-1:0] pat;
        logic [W-1:0] prev;
        tname = "nibbles";
        prev = 12'h020;
        for (int v = 15; v >= 0; v--) begin
            x = 4'(v);
            pat = {x, x, x};
            SW_IN = pat;
            for (int t = 1; t <= 20; t++) begin
                tick();
                if (t == 6) begin
                    n_cmp++;
                    if (SW_OUT !== pat || SW_CHG !== (pat ^ prev)) begin
                        n_err++;
                        $display("FAIL nibbles %h got %h/%h want %h/%h",
                                 pat, SW_OUT, SW_CHG, pat, pat ^ prev);
                    end
                end
            end
            prev = pat;
        end
    endtask

    task automatic test_reset_mid();
        tname = "reset_mid";
        SW_IN = 12'hA5A;
        repeat (3) tick();
        do_reset();
        check_acq(12'hA5A);
    endtask

    task automatic test_random();
        logic [W-1:0] flip;
        tname = "random";
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                flip = W'($urandom & $urandom);
                SW_IN = SW_IN ^ flip;
            end
            if (c == 200) begin
                do_reset();
            end
            tick();
        end
        SW_IN = W'($urandom);
        repeat (10) tick();
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RST_N = 1'b0;
        SW_IN = 12'hFFF;
        model_clear();
        #2;
        test_reset();
        test_clean_step();
        test_bounce();
        test_nibbles();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Conditions the twelve raw board slide switches before they reach `TOP`. Each channel is synchronised into the `CLK` domain and debounced: an input level must stay stable for a programmable number of cycles before it is accepted. Its outputs drive `TOP.SW[11:0]` directly. It also emits per-channel change pulses and a post-reset "inputs settled" flag.

## Interface
Parameters:
- `WIDTH`, 12: number of switch channels.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed to accept a new level (1 ms at 50 MHz). Legal range is 2 or more.
- `CNT_W`, 16: stability counter width. Requirement: 2^`CNT_W` > `DEBOUNCE_CYCLES`.

Ports:
- `CLK` in 1: system clock. This is the only clock.
- `RST_N` in 1: reset, asynchronous and active-low.
- `SW_IN` in `WIDTH`: raw switch levels. Asynchronous to `CLK` and may bounce.
- `SW_OUT` out `WIDTH`: debounced levels, feeding `TOP.SW`.
- `SW_CHG` out `WIDTH`: one-cycle pulse on a channel in the cycle its `SW_OUT` bit changes.
- `SW_VALID` out 1: high once the initial acquisition window after reset has elapsed. It then stays high until the next reset.

## Operation
Per channel, all channels independent:
- **Synchroniser.** Two flops, `s1 <= SW_IN[i]` and `s2 <= s1`. Both reset to 0.
- **Counter.**
  - If `s2 == SW_OUT[i]`: `cnt <= 0`.
  - Otherwise, if `cnt == DEBOUNCE_CYCLES-1`: `SW_OUT[i] <= s2`, `SW_CHG[i] <= 1`, `cnt <= 0`.
  - Otherwise: `cnt <= cnt+1`.
- **`SW_CHG`.** Deasserts on the next cycle unless the channel changes again. A re-change cannot occur sooner than `DEBOUNCE_CYCLES` cycles later.
- **Glitch rejection.** A mismatch lasting fewer than `DEBOUNCE_CYCLES` cycles at `s2` resets `cnt` when it ends and has no effect on `SW_OUT`. This holds however many times the channel bounces.
- **No wrap-around.** The counter never exceeds `DEBOUNCE_CYCLES-1`.
- **Acquisition.** A shared counter `acq` (width `CNT_W`+1) runs from reset release. It sets `SW_VALID` when it reaches `DEBOUNCE_CYCLES+2`, then holds.
- **Simultaneous changes.** Channels changing in the same cycle are accepted in the same cycle. Several `SW_CHG` bits may be high together.
- **Reset.** Asserting `RST_N` low at any time, including mid-count, asynchronously clears `s1`, `s2`, `cnt`, `acq`, `SW_OUT`, `SW_CHG` and `SW_VALID` to 0.

## Timing
- **Reset values.** `SW_OUT`=0, `SW_CHG`=0, `SW_VALID`=0.
- **Acceptance latency.** Let `SW_IN[i]` settle before edge k and stay stable.
  - `s2` reflects it at edge k+1.
  - `SW_OUT[i]` and `SW_CHG[i]` update at edge k+1+`DEBOUNCE_CYCLES`. That is `DEBOUNCE_CYCLES`+2 cycles counting edge k as cycle 1.
- **Settled flag.** `SW_VALID` rises at edge `DEBOUNCE_CYCLES`+3 after reset release. By then every channel held stable since reset has reached its true level.
- **Output registration.** All outputs are registered, with no combinational path from `SW_IN`.

## Structure
- **Shared package `sw_pkg`.**
  - `SW_WIDTH` = 12.
  - `SW_DEBOUNCE_DEFAULT` = 50000.
  - `SW_CNT_W` = 16.
  - A function `sw_cnt_w_ok(cycles, w)` used in an elaboration-time assertion of the counter-width rule.
- **Sub-module `debounce_ch`.** Single channel: synchroniser, counter, `SW_OUT` bit and `SW_CHG` bit. `sw_debounce` generates `WIDTH` instances of it and owns the `acq` counter.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, so acceptance latency is 6 cycles and `SW_VALID` rises at edge 7.
- **Reset and acquisition.** Hold `SW_IN`=12'hFFF through reset, then release. Required: `SW_OUT`=0 and `SW_VALID`=0 until edge 6. At edge 6 `SW_OUT`=12'hFFF with `SW_CHG`=12'hFFF for one cycle. At edge 7 `SW_VALID`=1.
- **Clean step on one channel.** From a settled state with `SW_IN`=0, set `SW_IN`=12'h001. Required: `SW_OUT` becomes 12'h001 exactly 6 cycles later. `SW_CHG` is 12'h001 for exactly one cycle. All other bits stay 0.
- **Bounce rejection.** Toggle bit 5 with high periods of 3 cycles and low periods of 1 cycle, for 20 cycles, then hold it high. Required: `SW_OUT[5]` stays 0 during the bouncing. It rises 6 cycles after the final stable high.
- **All nibbles swept.** Apply the pattern {X,X,X} for X = F down to 0, each held 20 cycles. Required: `SW_OUT` equals {X,X,X} 6 cycles after each step. `SW_CHG` marks exactly the bits that differ from the previous pattern.
- **Reset mid-count.** Step `SW_IN` to 12'hA5A and pull `RST_N` low 3 cycles later. Required: all outputs read 0 immediately, with no `SW_CHG` pulse. After release, 12'hA5A is accepted at edge 6 and `SW_VALID` rises at edge 7.
